// File: rtl/arm_alu_flag_stage_if.sv
// Handshake and operand bundle between the shifter, the execute ALU and writeback.
// The master modport drives instructions in and consumes results; the slave modport is the ALU stage.
interface arm_alu_flag_stage_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        cond;
    logic [3:0]        opcode;
    logic              s_bit;
    logic [3:0]        rd_idx;
    logic [DATA_W-1:0] rn;
    logic [DATA_W-1:0] op2;
    logic              shift_cout;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic [3:0]        rd_out;
    logic              rd_we;
    logic [3:0]        flags;

    modport master (
        output in_valid, cond, opcode, s_bit, rd_idx, rn, op2, shift_cout, out_ready,
        input  in_ready, out_valid, result, rd_out, rd_we, flags
    );

    modport slave (
        input  in_valid, cond, opcode, s_bit, rd_idx, rn, op2, shift_cout, out_ready,
        output in_ready, out_valid, result, rd_out, rd_we, flags
    );
endinterface

// File: rtl/arm_alu_flag_stage.sv
// ARM execute-stage ALU: condition check, 16 data-processing ops, NZCV register, one-entry output buffer.
// Optional macro ALU_PERF_CNT_EN adds exec_cnt/skip_cnt counters of passed and skipped instructions.
module arm_alu_flag_stage #(
    parameter int         DATA_W    = 32,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic                 clk,
    input  logic                 reset,
    arm_alu_flag_stage_if.slave  bus
`ifdef ALU_PERF_CNT_EN
    ,
    output logic [31:0]          exec_cnt,
    output logic [31:0]          skip_cnt
`endif
);

    logic              r_valid;
    logic [DATA_W-1:0] r_result;
    logic [3:0]        r_rd;
    logic              r_we;
    logic [3:0]        r_flags;

    logic              w_accept;
    logic              w_pass;
    logic              w_isCmp;
    logic              w_isArith;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic              w_cin;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_logic;
    logic [DATA_W-1:0] w_result;
    logic [3:0]        w_newFlags;

    wire w_n = r_flags[3];
    wire w_z = r_flags[2];
    wire w_c = r_flags[1];
    wire w_v = r_flags[0];

    assign bus.in_ready  = !r_valid | bus.out_ready;
    assign w_accept      = bus.in_valid & bus.in_ready;
    assign w_isCmp       = (bus.opcode[3:2] == 2'b10);

    always_comb begin
        w_pass = 1'b0;
        case (bus.cond)
            4'h0: w_pass = w_z;
            4'h1: w_pass = !w_z;
            4'h2: w_pass = w_c;
            4'h3: w_pass = !w_c;
            4'h4: w_pass = w_n;
            4'h5: w_pass = !w_n;
            4'h6: w_pass = w_v;
            4'h7: w_pass = !w_v;
            4'h8: w_pass = w_c & !w_z;
            4'h9: w_pass = !w_c | w_z;
            4'hA: w_pass = (w_n == w_v);
            4'hB: w_pass = (w_n != w_v);
            4'hC: w_pass = !w_z & (w_n == w_v);
            4'hD: w_pass = w_z | (w_n != w_v);
            4'hE: w_pass = 1'b1;
            default: w_pass = 1'b0;
        endcase
    end

    // Every arithmetic op is one adder: subtraction inverts an operand and uses carry-in 1 (or C).
    always_comb begin
        w_a       = bus.rn;
        w_b       = bus.op2;
        w_cin     = 1'b0;
        w_isArith = 1'b1;
        case (bus.opcode)
            4'h2, 4'hA: begin w_b = ~bus.op2; w_cin = 1'b1; end
            4'h3:       begin w_a = bus.op2; w_b = ~bus.rn; w_cin = 1'b1; end
            4'h4, 4'hB: w_cin = 1'b0;
            4'h5:       w_cin = w_c;
            4'h6:       begin w_b = ~bus.op2; w_cin = w_c; end
            4'h7:       begin w_a = bus.op2; w_b = ~bus.rn; w_cin = w_c; end
            default:    w_isArith = 1'b0;
        endcase
        w_sum = {1'b0, w_a} + {1'b0, w_b} + {{DATA_W{1'b0}}, w_cin};
    end

    always_comb begin
        w_logic = '0;
        case (bus.opcode)
            4'h0, 4'h8: w_logic = bus.rn & bus.op2;
            4'h1, 4'h9: w_logic = bus.rn ^ bus.op2;
            4'hC:       w_logic = bus.rn | bus.op2;
            4'hD:       w_logic = bus.op2;
            4'hE:       w_logic = bus.rn & ~bus.op2;
            4'hF:       w_logic = ~bus.op2;
            default:    w_logic = '0;
        endcase
    end

    // Logical ops take C from the shifter and leave V alone.
    always_comb begin
        w_result      = w_isArith ? w_sum[DATA_W-1:0] : w_logic;
        w_newFlags[3] = w_result[DATA_W-1];
        w_newFlags[2] = (w_result == '0);
        w_newFlags[1] = w_isArith ? w_sum[DATA_W] : bus.shift_cout;
        w_newFlags[0] = w_isArith ? ((w_a[DATA_W-1] == w_b[DATA_W-1]) &&
                                     (w_sum[DATA_W-1] != w_a[DATA_W-1]))
                                  : w_v;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_rd     <= 4'h0;
            r_we     <= 1'b0;
            r_flags  <= FLAGS_RST;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_result <= w_result;
            r_rd     <= bus.rd_idx;
            r_we     <= w_pass & !w_isCmp;
            if (w_pass & (bus.s_bit | w_isCmp))
                r_flags <= w_newFlags;
        end else if (bus.out_ready) begin
            r_valid  <= 1'b0;
        end
    end

`ifdef ALU_PERF_CNT_EN
    logic [31:0] r_execCnt;
    logic [31:0] r_skipCnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_execCnt <= 32'h0;
            r_skipCnt <= 32'h0;
        end else if (w_accept) begin
            if (w_pass)
                r_execCnt <= r_execCnt + 32'h1;
            else
                r_skipCnt <= r_skipCnt + 32'h1;
        end
    end

    assign exec_cnt = r_execCnt;
    assign skip_cnt = r_skipCnt;
`endif

    assign bus.out_valid = r_valid;
    assign bus.result    = r_result;
    assign bus.rd_out    = r_rd;
    assign bus.rd_we     = r_we;
    assign bus.flags     = r_flags;

endmodule

// File: tb/tb_arm_alu_flag_stage.sv
// Directed-vector bench for arm_alu_flag_stage with hand-computed results and NZCV values.
module tb_arm_alu_flag_stage;

    logic clk;
    logic reset;
    int   errorCount = 0;
    int   checkCount = 0;

    arm_alu_flag_stage_if #(.DATA_W(32)) bus ();

`ifdef ALU_PERF_CNT_EN
    logic [31:0] execCnt;
    logic [31:0] skipCnt;
`endif

    arm_alu_flag_stage #(.DATA_W(32), .FLAGS_RST(4'b0000)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus)
`ifdef ALU_PERF_CNT_EN
        ,
        .exec_cnt (execCnt),
        .skip_cnt (skipCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Presents one instruction with out_ready high, lets it be accepted, then withdraws it.
    task automatic applyStimulus(input logic [3:0] c, input logic [3:0] op, input logic s,
                                 input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b,
                                 input logic sc);
        bus.cond       = c;
        bus.opcode     = op;
        bus.s_bit      = s;
        bus.rd_idx     = rd;
        bus.rn         = a;
        bus.op2        = b;
        bus.shift_cout = sc;
        bus.in_valid   = 1'b1;
        bus.out_ready  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid   = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b1;
        bus.cond       = 4'h0;
        bus.opcode     = 4'h0;
        bus.s_bit      = 1'b0;
        bus.rd_idx     = 4'h0;
        bus.rn         = 32'h0;
        bus.op2        = 32'h0;
        bus.shift_cout = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_result",    bus.result,          32'h0);
        checkOutput("rst_rd_out",    32'(bus.rd_out),     32'h0);
        checkOutput("rst_rd_we",     32'(bus.rd_we),      32'd0);
        checkOutput("rst_flags",     32'(bus.flags),      32'h0);
        reset = 1'b0;
        checkOutput("rst_in_ready",  32'(bus.in_ready),   32'd1);

        // MOVS #0
        applyStimulus(4'hE, 4'hD, 1'b1, 4'h3, 32'h1234_5678, 32'h0, 1'b0);
        checkOutput("mov_out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("mov_result",    bus.result,          32'h0);
        checkOutput("mov_flags",     32'(bus.flags),      32'b0100);
        checkOutput("mov_rd_we",     32'(bus.rd_we),      32'd1);
        checkOutput("mov_rd_out",    32'(bus.rd_out),     32'h3);

        applyStimulus(4'hE, 4'h4, 1'b1, 4'h1, 32'h7FFF_FFFF, 32'h1, 1'b0);
        checkOutput("adds_result",   bus.result,          32'h8000_0000);
        checkOutput("adds_flags",    32'(bus.flags),      32'b1001);
        applyStimulus(4'hE, 4'h5, 1'b1, 4'h2, 32'hFFFF_FFFF, 32'h1, 1'b0);
        checkOutput("adcs_result",   bus.result,          32'h0);
        checkOutput("adcs_flags",    32'(bus.flags),      32'b0110);

        // CMP 5,5 then back-to-back MOVNE (fails) and MOVEQ (passes)
        applyStimulus(4'hE, 4'hA, 1'b0, 4'h4, 32'h5, 32'h5, 1'b0);
        checkOutput("cmp_flags",     32'(bus.flags),      32'b0110);
        checkOutput("cmp_rd_we",     32'(bus.rd_we),      32'd0);
        applyStimulus(4'h1, 4'hD, 1'b1, 4'h5, 32'h0, 32'h7, 1'b0);
        checkOutput("movne_valid",   32'(bus.out_valid), 32'd1);
        checkOutput("movne_rd_we",   32'(bus.rd_we),      32'd0);
        checkOutput("movne_flags",   32'(bus.flags),      32'b0110);
        checkOutput("movne_result",  bus.result,          32'h7);
`ifdef ALU_PERF_CNT_EN
        checkOutput("skip_cnt",      skipCnt,             32'd1);
        checkOutput("exec_cnt",      execCnt,             32'd4);
`endif
        applyStimulus(4'h0, 4'hD, 1'b0, 4'h6, 32'h0, 32'h9, 1'b0);
        checkOutput("moveq_rd_we",   32'(bus.rd_we),      32'd1);
        applyStimulus(4'hF, 4'hD, 1'b1, 4'h6, 32'h0, 32'h9, 1'b0);
        checkOutput("nv_rd_we",      32'(bus.rd_we),      32'd0);
        checkOutput("nv_flags",      32'(bus.flags),      32'b0110);

        // Borrow chain: SUBS 3-5 clears C, SBCS 10-3-1 = 6 sets C
        applyStimulus(4'hE, 4'h2, 1'b1, 4'h7, 32'h3, 32'h5, 1'b0);
        checkOutput("subs_result",   bus.result,          32'hFFFF_FFFE);
        checkOutput("subs_flags",    32'(bus.flags),      32'b1000);
        applyStimulus(4'hE, 4'h6, 1'b1, 4'h7, 32'hA, 32'h3, 1'b0);
        checkOutput("sbcs_result",   bus.result,          32'h6);
        checkOutput("sbcs_flags",    32'(bus.flags),      32'b0010);
        applyStimulus(4'hE, 4'h3, 1'b0, 4'h7, 32'h5, 32'h3, 1'b0);
        checkOutput("rsb_result",    bus.result,          32'hFFFF_FFFE);
        checkOutput("rsb_flags",     32'(bus.flags),      32'b0010);
        applyStimulus(4'hE, 4'hE, 1'b0, 4'h8, 32'hFF, 32'h0F, 1'b0);
        checkOutput("bic_result",    bus.result,          32'hF0);
        applyStimulus(4'hE, 4'hF, 1'b0, 4'h8, 32'h0, 32'h0, 1'b0);
        checkOutput("mvn_result",    bus.result,          32'hFFFF_FFFF);

        // Backpressure: buffer holds ADD 1+1 while ADD 2+2 waits
        applyStimulus(4'hE, 4'h4, 1'b0, 4'h9, 32'h1, 32'h1, 1'b0);
        checkOutput("bp_first",      bus.result,          32'h2);
        bus.out_ready = 1'b0;
        bus.rn        = 32'h2;
        bus.op2       = 32'h2;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_in_ready",  32'(bus.in_ready), 32'd0);
            checkOutput("bp_hold",      bus.result,         32'h2);
        end
        bus.out_ready = 1'b1;
        #1;
        checkOutput("bp_release_rdy", 32'(bus.in_ready),  32'd1);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        checkOutput("bp_second",     bus.result,          32'h4);
        checkOutput("bp_second_vld", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("bp_drained",    32'(bus.out_valid), 32'd0);

        // ANDS with V already set keeps V
        applyStimulus(4'hE, 4'h4, 1'b1, 4'h1, 32'h7FFF_FFFF, 32'h1, 1'b0);
        checkOutput("vset_flags",    32'(bus.flags),      32'b1001);
        applyStimulus(4'hE, 4'h0, 1'b1, 4'h1, 32'hF0, 32'h0F, 1'b1);
        checkOutput("ands_result",   bus.result,          32'h0);
        checkOutput("ands_flags",    32'(bus.flags),      32'b0111);

        // Asynchronous reset in the middle of a cycle
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("arst_flags",     32'(bus.flags),     32'h0);
        checkOutput("arst_result",    bus.result,         32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(4'hE, 4'hC, 1'b1, 4'hA, 32'h50, 32'h05, 1'b0);
        checkOutput("post_rst_result", bus.result,        32'h55);
        checkOutput("post_rst_valid",  32'(bus.out_valid), 32'd1);
        checkOutput("post_rst_flags",  32'(bus.flags),    32'b0000);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
